// File: rtl/lpc_pkg.sv
// lpc_pkg: shared constants, types and helpers for the LPC speech decoder.
// Frame layout, Q-format, excitation shifts, LFSR and saturation.
package lpc_pkg;

  localparam int ORDER       = 8;
  localparam int VOICED_BIT  = 79;
  localparam int PITCH_LSB   = 72;
  localparam int GAIN_LSB    = 64;
  localparam int COEF_MSB    = 63;
  localparam int COEF_W      = 8;
  localparam int QSHIFT      = 6;
  localparam int IMP_SHIFT   = 7;
  localparam int NOISE_SHIFT = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // feedback bits 15,13,12,10 (taps 16,14,13,11)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic signed [15:0] sat16(
    input logic signed [27:0] v
  );
    if (v > 28'sd32767)
      return 16'sh7FFF;
    else if (v < -28'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/lpc_synth_filter.sv
// lpc_synth_filter: 8-tap all-pole direct-form synthesis filter.
// Output is combinational from history; history shifts when enabled.
module lpc_synth_filter
  import lpc_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [ORDER*COEF_W-1:0]  coef_i,
  input  logic signed [16:0]       e_i,
  output logic signed [15:0]       y_o
);

  logic [ORDER-1:0][15:0] hist_q;
  logic [ORDER-1:0][15:0] h;
  logic signed [27:0]     acc;
  logic signed [27:0]     sum;
  logic signed [7:0]      c;

  // MAC over the history, seen as zero when an utterance restarts
  always_comb begin
    h   = clr_i ? '0 : hist_q;
    acc = '0;
    c   = '0;
    for (int k = 0; k < ORDER; k++) begin
      c   = $signed(coef_i[COEF_MSB-COEF_W*k -: COEF_W]);
      acc = acc + 28'($signed(h[k])) * 28'(c);
    end
    sum = (acc >>> QSHIFT) + 28'(e_i);
    y_o = sat16(sum);
  end

  // history register: newest saturated sample enters at index 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      hist_q <= '0;
    else if (en_i)
      hist_q <= {h[ORDER-2:0], y_o};
    else if (clr_i)
      hist_q <= '0;
  end

endmodule

// File: rtl/lpc_decoder.sv
// lpc_decoder: LPC frame in (AXI-Stream), PCM samples out (AXI-Stream).
// Optional de-emphasis stage enabled by defining LPC_DEEMPH_EN.
module lpc_decoder
  import lpc_pkg::*;
#(
  parameter int SAMPLES_PER_FRAME = 160
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic [79:0]        TDATA,
  input  logic               TVALID,
  output logic               TREADY,
  input  logic               TLAST,
  input  logic               TUSER,
  output logic signed [15:0] OUT_DECODED,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               OUT_LAST
);

  localparam logic [9:0] LAST_IDX = 10'(SAMPLES_PER_FRAME - 1);

  state_e             state_q, state_d;
  logic               init_q;
  logic [79:0]        frame_q;
  logic               tlast_q;
  logic [9:0]         cnt_q, cnt_d, cnt_eff;
  logic [6:0]         pc_q, pc_d, pc_eff, pc_nx;
  logic [15:0]        lfsr_q, lfsr_d, lfsr_eff, lfsr_nx;
  logic               ov_q, ol_q;
  logic signed [15:0] od_q;

  logic               idle, fire, clr, produce, last;
  logic [79:0]        fr;
  logic               tl, voiced;
  logic [6:0]         pitch;
  logic [16:0]        g17;
  logic signed [16:0] e;
  logic signed [15:0] y, smp;

  assign idle    = (state_q == IDLE);
  assign TREADY  = idle && init_q;
  assign fire    = TVALID && TREADY;
  assign clr     = fire && TUSER;
  // an accepted frame is used directly so its first sample has latency 1
  assign fr      = idle ? TDATA : frame_q;
  assign tl      = idle ? TLAST : tlast_q;
  assign produce = (!ov_q || OUT_READY) && (fire || !idle);
  assign cnt_eff = idle ? 10'd0 : cnt_q;
  assign last    = (cnt_eff == LAST_IDX);

  assign voiced   = fr[VOICED_BIT];
  assign pitch    = fr[PITCH_LSB +: 7];
  assign g17      = {9'd0, fr[GAIN_LSB +: 8]};
  assign pc_eff   = clr ? 7'd0 : pc_q;
  assign lfsr_eff = clr ? LFSR_SEED : lfsr_q;
  assign lfsr_nx  = {lfsr_eff[14:0], ^(lfsr_eff & LFSR_TAPS)};

  // excitation: pitch-pulse train when voiced, LFSR sign noise otherwise
  always_comb begin
    e     = '0;
    pc_nx = pc_eff;
    if (voiced) begin
      if (pc_eff == 7'd0) begin
        e     = $signed(g17 << IMP_SHIFT);
        pc_nx = (pitch == 7'd0) ? 7'd127 : pitch - 7'd1;
      end else begin
        pc_nx = pc_eff - 7'd1;
      end
    end else begin
      e = lfsr_eff[0] ? $signed(g17 << NOISE_SHIFT)
                      : -$signed(g17 << NOISE_SHIFT);
    end
  end

  lpc_synth_filter u_filt (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .en_i   (produce),
    .clr_i  (clr),
    .coef_i (fr[COEF_MSB:0]),
    .e_i    (e),
    .y_o    (y)
  );

`ifdef LPC_DEEMPH_EN
  logic signed [15:0] d_q, d_eff;
  logic signed [27:0] dsum;

  assign d_eff = clr ? 16'sd0 : d_q;
  assign dsum  = 28'(y) + ((28'(d_eff) * 28'sd15) >>> 4);
  assign smp   = sat16(dsum);

  // de-emphasis memory follows each produced output sample
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      d_q <= '0;
    else if (produce)
      d_q <= smp;
    else if (clr)
      d_q <= '0;
  end
`else
  assign smp = y;
`endif

  // next-state: frame sequencing, sample count, pitch and LFSR state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    lfsr_d  = lfsr_q;
    if (clr) begin
      pc_d   = 7'd0;
      lfsr_d = LFSR_SEED;
    end
    if (produce) begin
      pc_d    = pc_nx;
      lfsr_d  = voiced ? lfsr_eff : lfsr_nx;
      cnt_d   = cnt_eff + 10'd1;
      state_d = last ? IDLE : RUN;
    end else if (fire) begin
      cnt_d   = 10'd0;
      state_d = RUN;
    end
  end

  // state, frame latch and excitation registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      frame_q <= '0;
      tlast_q <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      lfsr_q  <= lfsr_d;
      if (fire) begin
        frame_q <= TDATA;
        tlast_q <= TLAST;
      end
    end
  end

  // output register: load on produce, hold while stalled
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      od_q <= '0;
    end else if (produce) begin
      ov_q <= 1'b1;
      ol_q <= last && tl;
      od_q <= smp;
    end else if (OUT_READY) begin
      ov_q <= 1'b0;
      ol_q <= 1'b0;
    end
  end

  assign OUT_VALID   = ov_q;
  assign OUT_LAST    = ol_q;
  assign OUT_DECODED = od_q;

endmodule

// File: tb/tb_lpc_decoder.sv
// tb_lpc_decoder: directed self-checking bench for lpc_decoder.
// Eight samples per frame; expected values computed by hand.
module tb_lpc_decoder;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic [79:0]        TDATA;
  logic               TVALID;
  logic               TREADY;
  logic               TLAST;
  logic               TUSER;
  logic signed [15:0] OUT_DECODED;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               OUT_LAST;

  int n_cmp = 0;
  int n_bad = 0;

  int pulse[8];
  int decay[8];
  int satur[8];
  int zeros[8];

  lpc_decoder #(.SAMPLES_PER_FRAME(8)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .TDATA       (TDATA),
    .TVALID      (TVALID),
    .TREADY      (TREADY),
    .TLAST       (TLAST),
    .TUSER       (TUSER),
    .OUT_DECODED (OUT_DECODED),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_LAST    (OUT_LAST)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(
    input bit v, input int p, input int g, input logic [63:0] a
  );
    return {v, 7'(p), 8'(g), a};
  endfunction

  task automatic send(input logic [79:0] d, input bit l, input bit u);
    int w = 0;
    @(negedge ACLK);
    OUT_READY = 1'b1;
    while (!TREADY && w < 50) begin
      @(negedge ACLK);
      w++;
    end
    if (!TREADY) begin
      chk("tready_wait", 0, 1);
      return;
    end
    TDATA  = d;
    TVALID = 1'b1;
    TLAST  = l;
    TUSER  = u;
    @(negedge ACLK);
    TVALID = 1'b0;
    TLAST  = 1'b0;
    TUSER  = 1'b0;
    chk("latency", OUT_VALID, 1);
  endtask

  task automatic collect(
    input int n, input int ex[8], input bit bp,
    input bit lst, input string nm
  );
    int i = 0;
    int cyc = 0;
    bit held = 0;
    int hv = 0;
    while (i < n && cyc < 200) begin
      OUT_READY = bp ? cyc[0] : 1'b1;
      if (held && OUT_VALID)
        chk({nm, "_hold"}, OUT_DECODED, hv);
      held = OUT_VALID && !OUT_READY;
      hv   = OUT_DECODED;
      if (OUT_VALID && OUT_READY) begin
        chk($sformatf("%s_y%0d", nm, i), OUT_DECODED, ex[i]);
        chk($sformatf("%s_last%0d", nm, i), OUT_LAST,
            int'(lst && i == n - 1));
        i++;
      end
      cyc++;
      @(negedge ACLK);
    end
    if (i < n) chk({nm, "_timeout"}, i, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pulse = '{2048, 0, 0, 0, 2048, 0, 0, 0};
    decay = '{2048, 1024, 512, 256, 128, 64, 32, 16};
    satur = '{32640, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    zeros = '{0, 0, 0, 0, 0, 0, 0, 0};

    ARESET    = 1'b1;
    TDATA     = '0;
    TVALID    = 1'b0;
    TLAST     = 1'b0;
    TUSER     = 1'b0;
    OUT_READY = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rst_tready", TREADY, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_last", OUT_LAST, 0);
    chk("rst_data", OUT_DECODED, 0);
    ARESET = 1'b0;
    #1 chk("tready_pre", TREADY, 0);
    @(negedge ACLK);
    chk("tready_post", TREADY, 1);

    send(mk(1, 4, 16, 64'h0), 1'b0, 1'b1);
    collect(8, pulse, 1'b0, 1'b0, "pulse");
    chk("pulse_drain", OUT_VALID, 0);
    chk("pulse_tready", TREADY, 1);

    send(mk(1, 127, 16, {8'h20, 56'h0}), 1'b0, 1'b1);
    collect(8, decay, 1'b0, 1'b0, "decay");
    chk("decay_drain", OUT_VALID, 0);

    send(mk(1, 127, 255, {8'h7F, 56'h0}), 1'b0, 1'b1);
    collect(8, satur, 1'b0, 1'b0, "sat");

    send(mk(0, 5, 0, 64'h7F80_1234_55AA_C3E0), 1'b0, 1'b1);
    collect(8, zeros, 1'b0, 1'b0, "unv");

    send(mk(1, 4, 16, 64'h0), 1'b1, 1'b1);
    collect(8, pulse, 1'b1, 1'b1, "bp");
    chk("bp_drain", OUT_VALID, 0);

    send(mk(1, 4, 16, 64'h0), 1'b0, 1'b1);
    collect(3, pulse, 1'b0, 1'b0, "pre_rst");
    ARESET = 1'b1;
    #1;
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_data", OUT_DECODED, 0);
    chk("mid_rst_tready", TREADY, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    send(mk(1, 4, 16, 64'h0), 1'b0, 1'b0);
    collect(8, pulse, 1'b0, 1'b0, "post_rst");
    chk("post_rst_drain", OUT_VALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lpc_decoder.md
Name: lpc_decoder

Overview:
- LPC speech synthesis back-end.
- Accepts one 80-bit parameter frame per AXI-Stream beat: voicing, pitch, gain and 8 direct-form predictor coefficients.
- For each frame, emits SAMPLES_PER_FRAME signed 16-bit PCM samples on an AXI-Stream master.
- Sits after the frame parser/deserializer and before the DAC/audio sink.

Parameters:
- SAMPLES_PER_FRAME, 160, output samples synthesized per accepted frame (legal range 1..1023).
- ORDER, 8, predictor order; fixed by the frame format and not overridable.

Ports:
- ACLK  in  1  system clock; everything on rising edge.
- ARESET  in  1  reset; one clock domain; asynchronous, active-high.
- TDATA  in  80  frame: [79] voiced, [78:72] pitch period (unsigned), [71:64] gain (unsigned), [63:56] a1 … [7:0] a8 (signed Q1.6).
- TVALID  in  1  frame valid.
- TREADY  out  1  decoder can accept a frame.
- TLAST  in  1  frame is last of utterance.
- TUSER  in  1  start of utterance: clear filter history, pitch phase, LFSR.
- OUT_DECODED  out  16  signed PCM sample.
- OUT_VALID  out  1  sample valid.
- OUT_READY  in  1  sink ready.
- OUT_LAST  out  1  final sample of a frame that carried TLAST.

Behaviour:
- Reset values: TREADY=0 while ARESET high, then 1 one cycle after deassert; OUT_VALID=0; OUT_LAST=0; OUT_DECODED=0; y history=0; pitch counter=0; LFSR=16'hACE1; state IDLE.
- FSM IDLE:
  - TREADY=1.
  - On TVALID&&TREADY, latch the frame and the TLAST flag.
  - If TUSER=1, also clear history, pitch counter and LFSR.
  - Go to RUN; sample counter=0.
- FSM RUN:
  - TREADY=0.
  - A sample is produced in a cycle where !OUT_VALID || OUT_READY.
  - The sample is loaded into the output register and OUT_VALID=1.
  - First sample is valid the cycle after frame acceptance (latency 1).
  - After loading sample SAMPLES_PER_FRAME-1, go to IDLE.
  - OUT_VALID stays until that beat is consumed.
  - A new frame may be accepted while the last sample is still pending; the next frame's first sample loads only once the pending sample is consumed.
- Output hold: while OUT_VALID && !OUT_READY, OUT_DECODED/OUT_LAST hold and the filter does not advance.
- OUT_LAST=1 only on the final sample of a frame whose latched TLAST=1.
- Excitation e (signed 17-bit), voiced:
  - When the pitch counter is 0: e=gain<<7 and counter reloads pitch-1 (pitch 0 treated as 128).
  - Otherwise e=0 and counter decrements.
  - The counter persists across frames.
- Excitation, unvoiced:
  - LFSR steps once per sample, taps 16,14,13,11, Fibonacci, shift toward MSB.
  - e = LFSR[0] ? +(gain<<4) : -(gain<<4).
- Synthesis:
  - acc = Σ a_k·y[n-k], 8 signed products 16×8, summed in 28 bits.
  - y = sat16((acc >>> 6) + e), arithmetic shift.
  - Saturate to [-32768, 32767].
  - History shifts with the saturated value.
- Frames whose history is not cleared continue seamlessly from the prior frame.
- Reset asserted mid-frame aborts immediately to reset values; a partial output frame is dropped.

Optional Feature:
- Macro LPC_DEEMPH_EN.
- When defined, a de-emphasis stage is inserted: out = sat16(y + (d·15>>>4)), where d is the previous de-emphasis output.
  - d is cleared on reset and TUSER.
  - d advances only when a sample is produced.
  - Latency is unchanged (same-cycle combinational).
- When undefined, OUT_DECODED = y.

Decomposition:
- Package lpc_pkg holds:
  - frame field bit positions;
  - Q-format shift (6);
  - LFSR seed/taps;
  - impulse shift 7 and noise shift 4;
  - sat16 function;
  - FSM state enum {IDLE, RUN}.
- One sub-module is natural: lpc_synth_filter, an 8-tap all-pole MAC with history and saturation, advanced by an enable.

Test Plan:
- Pulse train: voiced, pitch 4, gain 0x10, all a=0, SAMPLES_PER_FRAME=8 → 2048,0,0,0,2048,0,0,0; TREADY returns high after the 8th sample.
- Single-pole decay: voiced, pitch 127, gain 0x10, a1=0x20 (0.5), others 0 → 2048,1024,512,256,128,64,32,16.
- Saturation: voiced, pitch 127, gain 0xFF, a1=0x7F → 32640 then 32767 held; no wrap negative.
- Unvoiced, gain 0, any coefficients, fresh TUSER → all samples 0.
- Backpressure/TLAST: OUT_READY toggles every other cycle → data stable while stalled, no sample lost or duplicated; OUT_LAST only on sample 8 of a TLAST frame.
- Reset mid-frame: ARESET pulsed at sample 3 → OUT_VALID=0 immediately; the next frame with a=0 reproduces the first scenario exactly.
